tx_frm_sync: RTL and testbench

- Frame-synchronisation stage directly upstream of the Ethernet transmit engine.
- Watches the TX buffer producer pointer and reads each frame's descriptor qword through its own buffer read port.
- Presents the transmitter with frame length (qwords), last-qword byte enables and a start trigger.
- Retires or retries each frame after the transmitter's sync, and prefetches the next descriptor so back-to-back frames can be sent without a gap (rsk/rsk_tk).

---
 rtl/tx_pkg.sv | 28 ++
 rtl/tx_len_dec.sv | 19 +
 rtl/tx_frm_sync.sv | 213 +++++++++++++++++++++
 tb/tb_tx_frm_sync.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the TX frame-synchronisation stage: FSM encodings,
// length limits and descriptor field placement.
package tx_pkg;

    typedef enum logic [7:0] {
        ST_IDLE = 8'b0000_0001,
        ST_RD   = 8'b0000_0010,
        ST_DEC  = 8'b0000_0100,
        ST_WAIT = 8'b0000_1000,
        ST_BUSY = 8'b0001_0000,
        ST_STL1 = 8'b0010_0000,
        ST_STL2 = 8'b0100_0000,
        ST_HALT = 8'b1000_0000
    } tx_state_e;

    typedef enum logic [1:0] {
        PF_WAIT = 2'd0,
        PF_RD   = 2'd1,
        PF_DEC  = 2'd2,
        PF_DONE = 2'd3
    } pf_state_e;

    localparam int MIN_LEN_DEF = 60;
    localparam int MAX_LEN_DEF = 9600;
    localparam int LEN_LSB     = 0;
    localparam int LEN_W       = 16;

endpackage

// File: rtl/tx_len_dec.sv
// Descriptor byte length -> data qword count, last-qword byte enables and
// legality flag. Purely combinational.
module tx_len_dec
    import tx_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic [LEN_W-1:0] len_i,
    output logic [12:0]      qw_len_o,
    output logic [7:0]       lst_ben_o,
    output logic             illegal_o
);

    assign qw_len_o  = 13'((len_i + 16'd7) >> 3);
    assign lst_ben_o = (len_i[2:0] == 3'd0) ? 8'hFF : ((8'd1 << len_i[2:0]) - 8'd1);
    assign illegal_o = (32'(len_i) < 32'(MIN_LEN)) || (32'(len_i) > 32'(MAX_LEN));

endmodule

// File: rtl/tx_frm_sync.sv
// Frame sync ahead of the Ethernet transmitter: reads descriptors, triggers
// frames, retires/retries them and prefetches the next frame for back-to-back sends.
module tx_frm_sync
    import tx_pkg::*;
#(
    parameter int BW      = 9,
    parameter int MIN_LEN = MIN_LEN_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic          clk,
    input  logic          rst,
    output logic [BW-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    input  logic [BW:0]   committed_prod,
    input  logic [BW:0]   committed_cons,
    output logic          trig,
    output logic [12:0]   qw_len,
    output logic [7:0]    lst_ben,
    output logic          rsk,
    input  logic          rsk_tk,
    input  logic          sync,
    output logic          err
);

    localparam int PW = BW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    tx_state_e       state_q, state_d;
    pf_state_e       pf_q, pf_d;
    logic [PW-1:0]   head_q, head_d, nxt_head_q, nxt_head_d;
    logic [BW-1:0]   rd_addr_q, rd_addr_d;
    logic            trig_q, trig_d, rsk_q, rsk_d, err_q, err_d;
    logic [12:0]     qw_len_q, qw_len_d, nxt_qw_len_q, nxt_qw_len_d;
    logic [7:0]      lst_ben_q, lst_ben_d, nxt_lst_ben_q, nxt_lst_ben_d;
    logic            nxt_ill_q, nxt_ill_d;
    logic            rsk_tk_q;

    logic [PW-1:0]   avail_s, nxt_avail_s;
    logic [12:0]     cur_qw_s, pf_qw_s;
    logic [7:0]      cur_ben_s, pf_ben_s;
    logic            cur_ill_s, pf_ill_s, take_s;
    logic            unused_s;

    assign avail_s     = committed_prod - head_q;
    assign nxt_avail_s = committed_prod - nxt_head_q;
    assign take_s      = rsk_tk && !rsk_tk_q && rsk_q;
    assign unused_s    = ^rd_data[63:LEN_LSB+LEN_W];

    tx_len_dec #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) u_cur_dec (
        .len_i     (rd_data[LEN_LSB +: LEN_W]),
        .qw_len_o  (cur_qw_s),
        .lst_ben_o (cur_ben_s),
        .illegal_o (cur_ill_s)
    );

    tx_len_dec #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) u_pf_dec (
        .len_i     (rd_data[LEN_LSB +: LEN_W]),
        .qw_len_o  (pf_qw_s),
        .lst_ben_o (pf_ben_s),
        .illegal_o (pf_ill_s)
    );

    // Next-state and output-register logic for the frame FSM and prefetch substate
    always_comb begin
        state_d       = state_q;
        pf_d          = pf_q;
        head_d        = head_q;
        nxt_head_d    = nxt_head_q;
        rd_addr_d     = rd_addr_q;
        trig_d        = trig_q;
        rsk_d         = rsk_q;
        err_d         = err_q;
        qw_len_d      = qw_len_q;
        lst_ben_d     = lst_ben_q;
        nxt_qw_len_d  = nxt_qw_len_q;
        nxt_lst_ben_d = nxt_lst_ben_q;
        nxt_ill_d     = nxt_ill_q;
        case (state_q)
            ST_IDLE: begin
                if (avail_s != {PW{1'b0}}) begin
                    rd_addr_d = head_q[BW-1:0];
                    state_d   = ST_RD;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RD: state_d = ST_DEC;
            ST_DEC: begin
                if (cur_ill_s) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    qw_len_d  = cur_qw_s;
                    lst_ben_d = cur_ben_s;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (32'(avail_s) >= 32'(qw_len_q) + 32'd1) begin
                    trig_d     = 1'b1;
                    nxt_head_d = head_q + PTR_ONE + PW'(qw_len_q);
                    pf_d       = PF_WAIT;
                    state_d    = ST_BUSY;
                end else begin
                    state_d    = ST_WAIT;
                end
            end
            ST_BUSY: begin
                if (take_s) begin
                    // Back-to-back: the prefetched frame becomes current; sync is ignored.
                    head_d     = nxt_head_q;
                    qw_len_d   = nxt_qw_len_q;
                    lst_ben_d  = nxt_lst_ben_q;
                    nxt_head_d = nxt_head_q + PTR_ONE + PW'(nxt_qw_len_q);
                    rsk_d      = 1'b0;
                    pf_d       = PF_WAIT;
                end else if (sync) begin
                    trig_d  = 1'b0;
                    rsk_d   = 1'b0;
                    state_d = ST_STL1;
                end else begin
                    case (pf_q)
                        PF_WAIT: begin
                            if (nxt_avail_s != {PW{1'b0}}) begin
                                rd_addr_d = nxt_head_q[BW-1:0];
                                pf_d      = PF_RD;
                            end else begin
                                pf_d      = PF_WAIT;
                            end
                        end
                        PF_RD: pf_d = PF_DEC;
                        PF_DEC: begin
                            nxt_qw_len_d  = pf_qw_s;
                            nxt_lst_ben_d = pf_ben_s;
                            nxt_ill_d     = pf_ill_s;
                            pf_d          = PF_DONE;
                        end
                        PF_DONE: begin
                            if (!nxt_ill_q && (32'(nxt_avail_s) >= 32'(nxt_qw_len_q) + 32'd1)) begin
                                rsk_d = 1'b1;
                            end else begin
                                rsk_d = rsk_q;
                            end
                        end
                        default: pf_d = PF_WAIT;
                    endcase
                end
            end
            ST_STL1: state_d = ST_STL2;
            ST_STL2: begin
                // nxt_head_q always equals head+1+qw_len of the current frame here.
                if (committed_cons == nxt_head_q) begin
                    head_d  = nxt_head_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HALT: begin
                trig_d = 1'b0;
                rsk_d  = 1'b0;
            end
            default: begin
                trig_d  = 1'b0;
                rsk_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pf_q          <= PF_WAIT;
            head_q        <= {PW{1'b0}};
            nxt_head_q    <= {PW{1'b0}};
            rd_addr_q     <= {BW{1'b0}};
            trig_q        <= 1'b0;
            rsk_q         <= 1'b0;
            err_q         <= 1'b0;
            qw_len_q      <= 13'd0;
            lst_ben_q     <= 8'd0;
            nxt_qw_len_q  <= 13'd0;
            nxt_lst_ben_q <= 8'd0;
            nxt_ill_q     <= 1'b0;
            rsk_tk_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pf_q          <= pf_d;
            head_q        <= head_d;
            nxt_head_q    <= nxt_head_d;
            rd_addr_q     <= rd_addr_d;
            trig_q        <= trig_d;
            rsk_q         <= rsk_d;
            err_q         <= err_d;
            qw_len_q      <= qw_len_d;
            lst_ben_q     <= lst_ben_d;
            nxt_qw_len_q  <= nxt_qw_len_d;
            nxt_lst_ben_q <= nxt_lst_ben_d;
            nxt_ill_q     <= nxt_ill_d;
            rsk_tk_q      <= rsk_tk;
        end
    end

    assign rd_addr = rd_addr_q;
    assign trig    = trig_q;
    assign rsk     = rsk_q;
    assign err     = err_q;
    assign qw_len  = qw_len_q;
    assign lst_ben = lst_ben_q;

endmodule

// File: tb/tb_tx_frm_sync.sv
// Directed bench for tx_frm_sync: a BW=9 instance for the frame flows and a
// BW=4 instance for pointer wrap and full-buffer cases.
module tb_tx_frm_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  rd_addr;
    logic [63:0] rd_data;
    logic [9:0]  committed_prod, committed_cons;
    logic        trig, rsk, rsk_tk, sync, err;
    logic [12:0] qw_len;
    logic [7:0]  lst_ben;

    logic [3:0]  rd_addr4;
    logic [63:0] rd_data4;
    logic [4:0]  prod4, cons4;
    logic        trig4, rsk4, rsk_tk4, sync4, err4;
    logic [12:0] qw_len4;
    logic [7:0]  lst_ben4;

    logic [63:0] mem  [0:511];
    logic [63:0] mem4 [0:15];

    int n_vec = 0;
    int n_err = 0;

    tx_frm_sync #(.BW(9)) u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .committed_prod(committed_prod), .committed_cons(committed_cons),
        .trig(trig), .qw_len(qw_len), .lst_ben(lst_ben), .rsk(rsk),
        .rsk_tk(rsk_tk), .sync(sync), .err(err)
    );

    tx_frm_sync #(.BW(4)) u_dut4 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .committed_prod(prod4), .committed_cons(cons4),
        .trig(trig4), .qw_len(qw_len4), .lst_ben(lst_ben4), .rsk(rsk4),
        .rsk_tk(rsk_tk4), .sync(sync4), .err(err4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data  <= mem[rd_addr];
    always @(posedge clk) rd_data4 <= mem4[rd_addr4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic retire(input logic [9:0] cons);
        committed_cons = cons;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("retire_trig_low", {63'd0, trig}, 64'd0);
        tick();
        tick();
    endtask

    task automatic run4(input logic [4:0] pr, input logic [3:0] eaddr);
        prod4 = pr;
        for (int i = 0; i < 8 && !trig4; i++) tick();
        chk("w4_trig", {63'd0, trig4}, 64'd1);
        chk("w4_addr", {60'd0, rd_addr4}, {60'd0, eaddr});
        chk("w4_qw", {51'd0, qw_len4}, 64'd9);
        cons4 = pr;
        sync4 = 1'b1;
        tick();
        sync4 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; rsk_tk = 1'b0;
        committed_prod = 10'd0; committed_cons = 10'd0;
        sync4 = 1'b0; rsk_tk4 = 1'b0; prod4 = 5'd0; cons4 = 5'd0;
        for (int i = 0; i < 512; i++) mem[i] = 64'd0;
        for (int i = 0; i < 16; i++) mem4[i] = 64'd0;
        mem[0] = 64'd64; mem[9] = 64'd61; mem[18] = 64'd60;
        mem[27] = 64'd64; mem[36] = 64'd100; mem[50] = 64'd20;
        mem4[0] = 64'd72; mem4[10] = 64'd72; mem4[4] = 64'd72;
        mem4[14] = 64'd64; mem4[7] = 64'd64;

        #1;
        chk("rst_trig", {63'd0, trig}, 64'd0);
        chk("rst_rsk", {63'd0, rsk}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_qw", {51'd0, qw_len}, 64'd0);
        chk("rst_ben", {56'd0, lst_ben}, 64'd0);
        chk("rst_addr", {55'd0, rd_addr}, 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Single frame L=64: trig exactly 4 cycles later
        committed_prod = 10'd9;
        tick(); tick(); tick();
        chk("lat_early", {63'd0, trig}, 64'd0);
        tick();
        chk("f1_trig", {63'd0, trig}, 64'd1);
        chk("f1_qw", {51'd0, qw_len}, 64'd8);
        chk("f1_ben", {56'd0, lst_ben}, 64'hFF);
        chk("f1_addr", {55'd0, rd_addr}, 64'd0);
        chk("f1_rsk", {63'd0, rsk}, 64'd0);
        retire(10'd9);

        // L=61 at head 9
        committed_prod = 10'd18;
        tick(); tick(); tick(); tick();
        chk("f2_trig", {63'd0, trig}, 64'd1);
        chk("f2_qw", {51'd0, qw_len}, 64'd8);
        chk("f2_ben", {56'd0, lst_ben}, 64'h1F);
        chk("f2_addr", {55'd0, rd_addr}, 64'd9);
        retire(10'd18);

        // L=60 at head 18, then an underrun retry
        committed_prod = 10'd27;
        tick(); tick(); tick(); tick();
        chk("f3_trig", {63'd0, trig}, 64'd1);
        chk("f3_ben", {56'd0, lst_ben}, 64'h0F);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("ur_low0", {63'd0, trig}, 64'd0);
        tick(); tick();
        chk("ur_low2", {63'd0, trig}, 64'd0);
        tick();
        chk("ur_retrig", {63'd0, trig}, 64'd1);
        chk("ur_qw", {51'd0, qw_len}, 64'd8);
        chk("ur_ben", {56'd0, lst_ben}, 64'h0F);
        chk("ur_addr", {55'd0, rd_addr}, 64'd18);
        retire(10'd27);

        // Back-to-back: L=64 at 27, L=100 at 36; rsk needs prod >= 50
        committed_prod = 10'd49;
        tick(); tick(); tick(); tick();
        chk("b2b_trig", {63'd0, trig}, 64'd1);
        chk("b2b_addr", {55'd0, rd_addr}, 64'd27);
        for (int i = 0; i < 8; i++) tick();
        chk("b2b_rsk_short", {63'd0, rsk}, 64'd0);
        chk("b2b_pf_addr", {55'd0, rd_addr}, 64'd36);
        committed_prod = 10'd50;
        for (int i = 0; i < 6 && !rsk; i++) tick();
        chk("b2b_rsk", {63'd0, rsk}, 64'd1);
        rsk_tk = 1'b1;
        sync = 1'b1;
        tick();
        rsk_tk = 1'b0;
        sync = 1'b0;
        chk("b2b_trig_kept", {63'd0, trig}, 64'd1);
        chk("b2b_qw", {51'd0, qw_len}, 64'd13);
        chk("b2b_ben", {56'd0, lst_ben}, 64'h0F);
        chk("b2b_rsk_clr", {63'd0, rsk}, 64'd0);
        tick(); tick(); tick();
        chk("b2b_no_gap", {63'd0, trig}, 64'd1);
        chk("b2b_rsk_idle", {63'd0, rsk}, 64'd0);
        retire(10'd50);

        // Illegal L=20 halts with err
        committed_prod = 10'd51;
        tick(); tick(); tick();
        chk("ill_err", {63'd0, err}, 64'd1);
        chk("ill_trig", {63'd0, trig}, 64'd0);
        tick(); tick(); tick(); tick();
        chk("halt_trig", {63'd0, trig}, 64'd0);
        chk("halt_err", {63'd0, err}, 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("arst_err", {63'd0, err}, 64'd0);
        tick();
        rst = 1'b0;

        // Async reset mid-BUSY with rsk raised
        tick(); tick(); tick(); tick();
        chk("rb_trig", {63'd0, trig}, 64'd1);
        for (int i = 0; i < 8 && !rsk; i++) tick();
        chk("rb_rsk", {63'd0, rsk}, 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("arst_trig", {63'd0, trig}, 64'd0);
        chk("arst_rsk", {63'd0, rsk}, 64'd0);
        chk("arst_qw", {51'd0, qw_len}, 64'd0);
        tick();
        rst = 1'b0;

        // BW=4: three L=72 frames bring head to 30, then a frame across the wrap
        run4(5'd10, 4'd0);
        run4(5'd20, 4'd10);
        run4(5'd30, 4'd4);
        prod4 = 5'd6;
        for (int i = 0; i < 8; i++) tick();
        chk("wrap_short", {63'd0, trig4}, 64'd0);
        chk("wrap_addr", {60'd0, rd_addr4}, 64'd14);
        prod4 = 5'd7;
        tick();
        chk("wrap_trig", {63'd0, trig4}, 64'd1);
        chk("wrap_qw", {51'd0, qw_len4}, 64'd8);
        chk("wrap_ben", {56'd0, lst_ben4}, 64'hFF);
        cons4 = 5'd7;
        sync4 = 1'b1;
        tick();
        sync4 = 1'b0;
        tick();
        tick();

        // Full buffer (avail = 16) from head 7
        prod4 = 5'd23;
        for (int i = 0; i < 8 && !trig4; i++) tick();
        chk("full_trig", {63'd0, trig4}, 64'd1);
        chk("full_addr", {60'd0, rd_addr4}, 64'd7);
        for (int i = 0; i < 6; i++) tick();
        chk("full_rsk", {63'd0, rsk4}, 64'd0);
        chk("full_err", {63'd0, err4}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
